// File: rtl/button_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_ctrl
//  Purpose  : Per-button debounce, press detection and hold-to-repeat. The
//             resulting press/repeat events are arbitrated (lowest index
//             first) onto a single valid/ready event port.
//  Revision : 1.0  initial release
// ============================================================================
module button_event_ctrl #(
    parameter int               N_BTN       = 5,
    parameter int               DEB_CYCLES  = 1000000,
    parameter int               HOLD_CYCLES = 50000000,
    parameter int               REP_CYCLES  = 15000000,
    parameter logic [N_BTN-1:0] REPEAT_MASK = 5'b11110,
    localparam int              ID_W        = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_sync,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_repeat,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_drop
);

    // Counter widths: just wide enough to reach each terminal value.
    localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int REP_W  = (REP_CYCLES  > 1) ? $clog2(REP_CYCLES)  : 1;

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REP_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } chan_state_t;

    // ------------------------------------------------------------------
    // Shared per-channel signals
    // ------------------------------------------------------------------
    logic [N_BTN-1:0] btn_level_q;
    logic [N_BTN-1:0] w_level_d;     // debounced level to be loaded this edge
    logic [N_BTN-1:0] w_raise;       // channel raises an event this cycle
    logic [N_BTN-1:0] w_raise_rep;   // ... and it is an auto-repeat

    logic [N_BTN-1:0] pend_q,     pend_d;
    logic [N_BTN-1:0] pend_rep_q, pend_rep_d;
    logic [N_BTN-1:0] w_grant;
    logic             w_drop;

    logic             evt_valid_q,  evt_valid_d;
    logic [ID_W-1:0]  evt_id_q,     evt_id_d;
    logic             evt_repeat_q, evt_repeat_d;
    logic             evt_drop_q;

    // ------------------------------------------------------------------
    // Per-channel debounce and press/repeat FSM
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        logic [DEB_W-1:0]  deb_cnt_q,  deb_cnt_d;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
        logic [REP_W-1:0]  rep_cnt_q,  rep_cnt_d;
        chan_state_t       state_q,    state_d;
        logic              lvl_nxt;
        logic              raise;
        logic              raise_rep;

        // Count consecutive mismatch cycles; flip the level on the last one.
        always_comb begin
            deb_cnt_d = '0;
            lvl_nxt   = btn_level_q[i];
            if (btn_sync[i] != btn_level_q[i]) begin
                if (deb_cnt_q == DEB_LAST) begin
                    lvl_nxt = ~btn_level_q[i];
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
        end

        // Debounce counter register.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_d;
            end
        end

        // FSM next state: the FSM follows the level being loaded this edge so
        // the press event lands in the pending store together with the level.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            raise      = 1'b0;
            raise_rep  = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (lvl_nxt) begin
                        raise      = 1'b1;
                        state_d    = ST_HELD;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end
                end
                ST_HELD: begin
                    if (!lvl_nxt) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        // Masked channels park here with the counter saturated.
                        if (REPEAT_MASK[i]) begin
                            raise      = 1'b1;
                            raise_rep  = 1'b1;
                            state_d    = ST_REPEAT;
                            hold_cnt_d = '0;
                            rep_cnt_d  = '0;
                        end
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!lvl_nxt) begin
                        state_d   = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == REP_LAST) begin
                        raise     = 1'b1;
                        raise_rep = 1'b1;
                        rep_cnt_d = '0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = '0;
                    rep_cnt_d  = '0;
                end
            endcase
        end

        // FSM state and hold/repeat counter registers.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q    <= ST_IDLE;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
            end else begin
                state_q    <= state_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
            end
        end

        assign w_level_d[i]   = lvl_nxt;
        assign w_raise[i]     = raise;
        assign w_raise_rep[i] = raise_rep;
    end

    // Debounced level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_level_q <= '0;
        end else begin
            btn_level_q <= w_level_d;
        end
    end

    // ------------------------------------------------------------------
    // Arbiter: the output register reloads when empty or being accepted
    // and takes the lowest-index pending channel.
    // ------------------------------------------------------------------
    logic w_load;
    logic w_any;
    logic [ID_W-1:0] w_pick;

    assign w_load = !evt_valid_q || evt_ready;
    assign w_any  = |pend_q;

    // Lowest set bit wins; isolate it as a one-hot grant.
    always_comb begin
        w_pick = '0;
        for (int j = N_BTN - 1; j >= 0; j--) begin
            if (pend_q[j]) begin
                w_pick = ID_W'(j);
            end
        end
        w_grant = w_load ? (pend_q & (~pend_q + 1'b1)) : '0;
    end

    // Output register next state; holds its contents while stalled.
    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_id_d     = evt_id_q;
        evt_repeat_d = evt_repeat_q;
        if (w_load) begin
            evt_valid_d = w_any;
            if (w_any) begin
                evt_id_d     = w_pick;
                evt_repeat_d = pend_rep_q[w_pick];
            end
        end
    end

    // Pending store: a fresh event on a channel still waiting (and not being
    // granted) is coalesced away; a grant and a new event together keep it set.
    always_comb begin
        pend_d     = pend_q;
        pend_rep_d = pend_rep_q;
        w_drop     = 1'b0;
        for (int j = 0; j < N_BTN; j++) begin
            if (w_raise[j]) begin
                if (pend_q[j] && !w_grant[j]) begin
                    w_drop = 1'b1;
                end else begin
                    pend_d[j]     = 1'b1;
                    pend_rep_d[j] = w_raise_rep[j];
                end
            end else if (w_grant[j]) begin
                pend_d[j] = 1'b0;
            end
        end
    end

    // Pending flags, output register and drop pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= '0;
            pend_rep_q   <= '0;
            evt_valid_q  <= 1'b0;
            evt_id_q     <= '0;
            evt_repeat_q <= 1'b0;
            evt_drop_q   <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_rep_q   <= pend_rep_d;
            evt_valid_q  <= evt_valid_d;
            evt_id_q     <= evt_id_d;
            evt_repeat_q <= evt_repeat_d;
            evt_drop_q   <= w_drop;
        end
    end

    assign evt_valid  = evt_valid_q;
    assign evt_id     = evt_id_q;
    assign evt_repeat = evt_repeat_q;
    assign btn_level  = btn_level_q;
    assign evt_drop   = evt_drop_q;

endmodule
`default_nettype wire
